// File: rtl/offset_calibration_sequencer.sv
// Offset calibration sequencer: settles, averages 2^LOG2_SAMPLES samples,
// writes the negated mean to cal address 1 and flushes the pipeline.
module offset_calibration_sequencer #(
    parameter int DATA_PATH_WIDTH = 16,
    parameter int LOG2_SAMPLES    = 6,
    parameter int SETTLE_SAMPLES  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [2:0]                 host_cal_address,
    input  logic [15:0]                host_cal_data,
    input  logic                       host_cal_we,
    input  logic [DATA_PATH_WIDTH-1:0] sample_data,
    input  logic                       sample_valid,
    output logic [2:0]                 cal_address,
    output logic [15:0]                cal_data,
    output logic                       cal_we,
    output logic                       pipeline_flush,
    output logic                       busy,
    output logic                       done,
    output logic                       host_reject,
    output logic [DATA_PATH_WIDTH-1:0] measured_offset
);

    localparam int DPW   = DATA_PATH_WIDTH;
    localparam int ACC_W = DPW + LOG2_SAMPLES;
    localparam int SET_W = $clog2(SETTLE_SAMPLES + 1);
    localparam int CNT_W = (LOG2_SAMPLES + 1 > SET_W) ? LOG2_SAMPLES + 1 : SET_W;

    localparam logic [CNT_W-1:0] SETTLE_LAST =
        CNT_W'(SETTLE_SAMPLES > 0 ? SETTLE_SAMPLES - 1 : 0);
    localparam logic [CNT_W-1:0] ACCUM_LAST =
        CNT_W'((1 << LOG2_SAMPLES) - 1);
    localparam logic signed [DPW-1:0] MEAN_MIN = {1'b1, {(DPW-1){1'b0}}};
    localparam logic signed [DPW-1:0] OFFS_MAX = ~MEAN_MIN;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACCUM,
        COMPUTE,
        WRITE,
        FLUSH
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    logic [2:0]              cal_address_d;
    logic [15:0]             cal_data_d;
    logic                    cal_we_d;
    logic                    flush_d;
    logic                    busy_d;
    logic                    done_d;
    logic                    reject_d;
    logic [DPW-1:0]          offset_d;

    logic signed [ACC_W-1:0] sample_ext;
    logic signed [DPW-1:0]   mean_w;
    logic signed [DPW-1:0]   offset_w;

    // Upper DPW bits of the accumulator are the floor-divided mean.
    assign sample_ext = ACC_W'($signed(sample_data));
    assign mean_w     = acc_q[ACC_W-1:LOG2_SAMPLES];
    assign offset_w   = (mean_w == MEAN_MIN) ? OFFS_MAX : -mean_w;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        cal_address_d = cal_address;
        cal_data_d    = cal_data;
        cal_we_d      = 1'b0;
        flush_d       = 1'b0;
        done_d        = 1'b0;
        reject_d      = 1'b0;
        offset_d      = measured_offset;

        if (host_cal_we) begin
            if (state_q == IDLE) begin
                cal_we_d      = 1'b1;
                cal_address_d = host_cal_address;
                cal_data_d    = host_cal_data;
            end else begin
                reject_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = (SETTLE_SAMPLES == 0) ? ACCUM : SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (sample_valid) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ACCUM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (sample_valid) begin
                    acc_d = acc_q + sample_ext;
                    if (cnt_q == ACCUM_LAST) begin
                        state_d = COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            COMPUTE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    offset_d      = offset_w;
                    cal_we_d      = 1'b1;
                    cal_address_d = 3'd1;
                    cal_data_d    = 16'(offset_w);
                    state_d       = WRITE;
                end
            end
            WRITE: begin
                flush_d = 1'b1;
                done_d  = 1'b1;
                state_d = FLUSH;
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            acc_q           <= '0;
            cal_address     <= '0;
            cal_data        <= '0;
            cal_we          <= 1'b0;
            pipeline_flush  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            host_reject     <= 1'b0;
            measured_offset <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            acc_q           <= acc_d;
            cal_address     <= cal_address_d;
            cal_data        <= cal_data_d;
            cal_we          <= cal_we_d;
            pipeline_flush  <= flush_d;
            busy            <= busy_d;
            done            <= done_d;
            host_reject     <= reject_d;
            measured_offset <= offset_d;
        end
    end

endmodule

// File: tb/tb_offset_calibration_sequencer.sv
// Randomized bench for offset_calibration_sequencer against a
// sample-count/mean reference model.
module tb_offset_calibration_sequencer;

    localparam int S = 8;
    localparam int A = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  host_cal_address = '0;
    logic [15:0] host_cal_data = '0;
    logic        host_cal_we = 1'b0;
    logic [15:0] sample_data = '0;
    logic        sample_valid = 1'b0;
    logic [2:0]  cal_address;
    logic [15:0] cal_data;
    logic        cal_we;
    logic        pipeline_flush;
    logic        busy;
    logic        done;
    logic        host_reject;
    logic [15:0] measured_offset;

    offset_calibration_sequencer #(
        .DATA_PATH_WIDTH(16),
        .LOG2_SAMPLES(6),
        .SETTLE_SAMPLES(S)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .abort(abort),
        .host_cal_address(host_cal_address),
        .host_cal_data(host_cal_data),
        .host_cal_we(host_cal_we),
        .sample_data(sample_data),
        .sample_valid(sample_valid),
        .cal_address(cal_address),
        .cal_data(cal_data),
        .cal_we(cal_we),
        .pipeline_flush(pipeline_flush),
        .busy(busy),
        .done(done),
        .host_reject(host_reject),
        .measured_offset(measured_offset)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: valids still needed, post-sample cycle count.
    bit          m_run = 0;
    int          m_need = 0;
    int          m_tail = 0;
    int          m_q[$];
    logic [15:0] m_off = '0;
    logic [2:0]  m_addr = '0;
    logic [15:0] m_data = '0;
    bit          m_we = 0;
    bit          m_flush = 0;
    bit          m_done = 0;
    bit          m_rej = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_compute();
        longint sum = 0;
        longint mean;
        longint off;
        foreach (m_q[i]) sum += m_q[i];
        if (sum >= 0) mean = sum / A;
        else mean = -((-sum + A - 1) / A);
        off = -mean;
        if (off > 32767) off = 32767;
        m_off = 16'(off);
    endtask

    task automatic model_edge();
        m_we    = 0;
        m_flush = 0;
        m_done  = 0;
        m_rej   = 0;
        if (reset) begin
            m_run  = 0;
            m_off  = '0;
            m_addr = '0;
            m_data = '0;
        end else begin
            if (host_cal_we) begin
                if (!m_run) begin
                    m_we   = 1;
                    m_addr = host_cal_address;
                    m_data = host_cal_data;
                end else begin
                    m_rej = 1;
                end
            end
            if (!m_run) begin
                if (start) begin
                    m_run  = 1;
                    m_need = S + A;
                    m_tail = 0;
                    m_q.delete();
                end
            end else if (m_need > 0) begin
                if (abort) begin
                    m_run = 0;
                end else if (sample_valid) begin
                    if (m_need <= A) m_q.push_back(int'($signed(sample_data)));
                    m_need--;
                    if (m_need == 0) m_tail = 1;
                end
            end else begin
                case (m_tail)
                    1: begin
                        if (abort) begin
                            m_run = 0;
                        end else begin
                            model_compute();
                            m_we   = 1;
                            m_addr = 3'd1;
                            m_data = m_off;
                            m_tail = 2;
                        end
                    end
                    2: begin
                        m_flush = 1;
                        m_done  = 1;
                        m_tail  = 3;
                    end
                    default: m_run = 0;
                endcase
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("cal_we", {31'd0, cal_we}, {31'd0, m_we});
        check("cal_address", {29'd0, cal_address}, {29'd0, m_addr});
        check("cal_data", {16'd0, cal_data}, {16'd0, m_data});
        check("flush", {31'd0, pipeline_flush}, {31'd0, m_flush});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("busy", {31'd0, busy}, {31'd0, m_run});
        check("reject", {31'd0, host_reject}, {31'd0, m_rej});
        check("measured", {16'd0, measured_offset}, {16'd0, m_off});
        start       = 0;
        abort       = 0;
        reset       = 0;
        host_cal_we = 0;
    endtask

    function automatic logic [15:0] gen(input int mode, input int n);
        int v;
        case (mode)
            1: v = (n < S) ? 1000 : 100;
            2: v = (n % 2 == 1) ? -4 : -3;
            3: v = -32768;
            4: v = 32767;
            default: v = int'($urandom_range(65535));
        endcase
        return 16'(v);
    endfunction

    task automatic host_write();
        host_cal_we      = 1;
        host_cal_address = 3'($urandom_range(7));
        host_cal_data    = 16'($urandom);
    endtask

    task automatic run(input int mode, input int gap, input int abort_at,
                       input int reset_at, input int host_at,
                       input bit chk, input logic [15:0] exp_off);
        int vcnt = 0;
        start = 1;
        if (host_at == 0) host_write();
        step();
        for (int k = 1; k < 3000 && m_run; k++) begin
            sample_valid = ($urandom_range(99) >= gap);
            sample_data  = gen(mode, vcnt);
            if (sample_valid) vcnt++;
            abort = (k == abort_at);
            reset = (k == reset_at);
            if (k == host_at) host_write();
            if ($urandom_range(19) == 0) start = 1;
            step();
        end
        check("run_timeout", {31'd0, m_run}, 32'd0);
        sample_valid = 0;
        if (chk) check("spec_offset", {16'd0, measured_offset}, {16'd0, exp_off});
        step();
        step();
    endtask

    initial begin
        step();
        step();
        // Host pass-through while idle.
        host_cal_we      = 1;
        host_cal_address = 3'd2;
        host_cal_data    = 16'd3;
        step();
        check("host_fwd_we", {31'd0, cal_we}, 32'd1);
        check("host_fwd_addr", {29'd0, cal_address}, 32'd2);
        check("host_fwd_data", {16'd0, cal_data}, 32'd3);
        check("host_fwd_rej", {31'd0, host_reject}, 32'd0);
        step();

        run(1, 0, -1, -1, -1, 1, 16'hFF9C);
        run(2, 30, -1, -1, -1, 1, 16'd4);
        run(3, 20, -1, -1, -1, 1, 16'h7FFF);
        run(4, 20, -1, -1, -1, 1, 16'h8001);
        run(1, 0, -1, -1, 20, 1, 16'hFF9C);
        run(0, 25, 40, -1, -1, 0, 16'h0);
        run(0, 0, 73, -1, -1, 0, 16'h0);
        run(1, 0, 74, -1, -1, 1, 16'hFF9C);
        run(0, 10, -1, 5, 3, 0, 16'h0);
        run(1, 15, -1, -1, 0, 1, 16'hFF9C);
        for (int i = 0; i < 4; i++) begin
            run(0, int'($urandom_range(50)), -1, -1,
                int'($urandom_range(90)), 0, 16'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
